scan_loc_sequencer: RTL and testbench
=====================================

Name: scan_loc_sequencer

Overview:
- On-chip scan pattern applicator for b12's two-chain scan insertion (test_si1/so1, test_si2/so2, test_se) running transition-delay, launch-on-capture (LOC) patterns.
- Consumes a per-shift-cycle pattern stream and drives the DUT scan inputs and a DUT clock enable.
- Compares unloaded scan-out bits against masked expectations and accumulates a fail count.
- Sits directly upstream of the scanned b12 core and replaces the external tester in silicon/emulation.

Parameters:
CHAIN_LEN, 61, flops per scan chain (both chains padded to equal length)
SE_SETTLE, 2, idle cycles after test_se falls and after test_se rises
CNT_W, 16, width of pattern and fail counters

Ports:
clock  in  1  single system clock; all logic posedge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a session from IDLE (ignored otherwise)
abort  in  1  synchronous; forces IDLE next cycle, counters kept
in_valid  in  1  stream word valid
in_ready  out  1  stream word accepted when in_valid & in_ready
in_si  in  2  load bits [0]=chain1, [1]=chain2
in_exp  in  2  expected unload bits of previous pattern
in_mask  in  2  1 = compare this bit
in_last  in  1  marks a word of the final unload-only pass; no launch/capture follows it
test_so_in  in  2  DUT test_so1/test_so2
test_si_out  out  2  to DUT test_si1/test_si2
test_se  out  1  DUT scan enable
dut_clk_en  out  1  DUT clock gate enable; one DUT edge per asserted cycle
busy  out  1  high outside IDLE/DONE
done  out  1  high in DONE until next start
fail  out  1  sticky, any masked miscompare this session
fail_cnt  out  CNT_W  miscompare bit count, saturating
pat_cnt  out  CNT_W  completed launch/capture pairs
first_fail_pat  out  CNT_W  pat_cnt value at first miscompare

Behaviour:
- Reset values: test_si_out=0, test_se=0, dut_clk_en=0, in_ready=0, busy=0, done=0, fail=0, all counters 0, state IDLE.
- States: IDLE, SE_RISE, SHIFT, SE_FALL, LAUNCH, CAPTURE, DONE.
- IDLE: start -> SE_RISE; clear fail, fail_cnt, pat_cnt, first_fail_pat; clear done.
- SE_RISE:
  - test_se=1, dut_clk_en=0 for SE_SETTLE cycles -> SHIFT with shift_cnt=0.
- SHIFT:
  - test_se=1; in_ready=1.
  - On a handshake cycle: dut_clk_en=1 and test_si_out=in_si, both combinational from the accepted word. test_so_in is compared in the same cycle, before the DUT edge, and shift_cnt increments.
  - No handshake: dut_clk_en=0, nothing advances (stall; no DUT edge).
  - After CHAIN_LEN accepted words: if the final word had in_last=1 -> DONE; otherwise -> SE_FALL.
  - in_last is sampled only on the CHAIN_LEN-th word.
- SE_FALL: test_se=0, dut_clk_en=0 for SE_SETTLE cycles -> LAUNCH.
- LAUNCH: test_se=0, dut_clk_en=1 for exactly 1 cycle -> CAPTURE.
- CAPTURE:
  - test_se=0, dut_clk_en=1 for exactly 1 cycle, back-to-back with LAUNCH (at-speed pair).
  - pat_cnt++ -> SE_RISE.
- DONE: done=1, busy=0, test_se=0; start -> new session.
- Compare: on each handshake, per chain i, miscompare = in_mask[i] & (test_so_in[i] ^ in_exp[i]).
  - fail_cnt adds 0, 1 or 2 (both chains same cycle), saturating at all-ones.
  - fail is set on the first miscompare; first_fail_pat latches pat_cnt only on that first miscompare.
  - Counter updates are registered (visible next cycle).
- The first pattern's unload carries power-up garbage; the host masks it (in_mask=0). The block does not special-case it.
- abort: synchronous.
  - Next cycle IDLE, test_se=0, dut_clk_en=0.
  - A handshake coincident with abort is still accepted and compared; no further words are accepted.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- Asynchronous reset mid-shift: outputs go to reset values immediately. Chain contents in the DUT are undefined afterwards.
- pat_cnt wraps at 2^CNT_W (not saturating).

Decomposition:
- Package scan_seq_pkg:
  - state enum;
  - SE_SETTLE default;
  - function for shift counter width, clog2(CHAIN_LEN+1).
- One sub-module, scan_unload_cmp: per-chain mask/compare, saturating fail_cnt, sticky fail, first_fail_pat latch.
- The FSM, counters and stream handshake stay in the top.

Test Plan:
- CHAIN_LEN=4, SE_SETTLE=2, in_valid always 1, 2 patterns + final unload pass, all masks 0:
  - 12 dut_clk_en pulses during SHIFT, plus 2 LAUNCH/CAPTURE pairs;
  - pat_cnt=2, done=1, fail=0;
  - test_se low for exactly 4 cycles (2 settle + LAUNCH + CAPTURE) per pattern.
- CHAIN_LEN=4, DUT modelled as two 4-bit shift registers, load 4'b1010 / 4'b0110, capture models identity:
  - unload with exact expectations, mask=2'b11 -> fail_cnt=0;
  - flip one expectation bit -> fail_cnt=1, first_fail_pat=1.
- Deassert in_valid for 3 cycles mid-SHIFT:
  - dut_clk_en=0 and shift_cnt frozen for those cycles;
  - total accepted words per pattern still 4;
  - no extra DUT edges.
- Both chains miscompare every word with fail_cnt preset near 16'hFFFE: fail_cnt saturates at 16'hFFFF and does not wrap.
- abort asserted in SE_FALL:
  - IDLE next cycle, test_se=0, no LAUNCH pulse, pat_cnt unchanged;
  - a subsequent start clears counters and runs normally.
- Assert reset (low) during CAPTURE:
  - dut_clk_en, test_se, busy drop to 0 in the same cycle (asynchronously);
  - after release the FSM sits in IDLE with all counters 0.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared types and sizing helpers for the LOC scan pattern sequencer.
package scan_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SE_RISE,
    ST_SHIFT,
    ST_SE_FALL,
    ST_LAUNCH,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam int SE_SETTLE_DEF = 2;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int shift_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_unload_cmp.sv
// Masked compare of unloaded scan-out bits with saturating miscompare count,
// sticky fail flag and the pattern index of the first miscompare.
module scan_unload_cmp #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             cmp_en_i,
  input  logic [1:0]       so_i,
  input  logic [1:0]       exp_i,
  input  logic [1:0]       mask_i,
  input  logic [CNT_W-1:0] pat_cnt_i,
  output logic             fail_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] first_fail_pat_o
);

  logic             fail_q, fail_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] ffp_q, ffp_d;
  logic [1:0]       miss;
  logic [1:0]       nmiss;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign miss  = mask_i & (so_i ^ exp_i);
  assign nmiss = {1'b0, miss[0]} + {1'b0, miss[1]};

  always_comb begin
    fail_d     = fail_q;
    fail_cnt_d = fail_cnt_q;
    ffp_d      = ffp_q;
    if (clear_i) begin
      fail_d     = 1'b0;
      fail_cnt_d = '0;
      ffp_d      = '0;
    end else if (cmp_en_i && (miss != 2'b00)) begin
      fail_d     = 1'b1;
      fail_cnt_d = sat_add(fail_cnt_q, nmiss);
      if (!fail_q) ffp_d = pat_cnt_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
      ffp_q      <= '0;
    end else begin
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
      ffp_q      <= ffp_d;
    end
  end

  assign fail_o           = fail_q;
  assign fail_cnt_o       = fail_cnt_q;
  assign first_fail_pat_o = ffp_q;

endmodule

// File: rtl/scan_loc_sequencer.sv
// Launch-on-capture scan pattern applicator for a two-chain scanned core:
// streams load/unload words through the chains and pulses an at-speed LAUNCH/CAPTURE pair.
module scan_loc_sequencer
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN = 61,
  parameter int SE_SETTLE = SE_SETTLE_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_si,
  input  logic [1:0]       in_exp,
  input  logic [1:0]       in_mask,
  input  logic             in_last,
  input  logic [1:0]       test_so_in,
  output logic [1:0]       test_si_out,
  output logic             test_se,
  output logic             dut_clk_en,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] pat_cnt,
  output logic [CNT_W-1:0] first_fail_pat
);

  localparam int SC_W = shift_cnt_w(CHAIN_LEN);
  localparam int ST_W = shift_cnt_w(SE_SETTLE);

  state_e           state_q;
  logic [SC_W-1:0]  shift_cnt_q;
  logic [ST_W-1:0]  settle_q;
  logic [CNT_W-1:0] pat_cnt_q;
  logic             idle_like, session_start, hs, last_word, settle_end;

  assign idle_like     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign session_start = idle_like && start && !abort;
  assign in_ready      = (state_q == ST_SHIFT);
  assign hs            = in_valid && in_ready;
  assign last_word     = (shift_cnt_q == SC_W'(CHAIN_LEN - 1));
  assign settle_end    = (settle_q == ST_W'(SE_SETTLE - 1));

  // Shift edges follow the accepted word directly so the DUT clocks in the same cycle.
  assign test_se     = (state_q == ST_SE_RISE) || (state_q == ST_SHIFT);
  assign dut_clk_en  = hs || (state_q == ST_LAUNCH) || (state_q == ST_CAPTURE);
  assign test_si_out = hs ? in_si : 2'b00;
  assign busy        = !idle_like;
  assign done        = (state_q == ST_DONE);
  assign pat_cnt     = pat_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      settle_q    <= '0;
      pat_cnt_q   <= '0;
    end else if (abort) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_SE_RISE;
            settle_q  <= '0;
            pat_cnt_q <= '0;
          end
        end
        ST_SE_RISE: begin
          if (settle_end) begin
            state_q     <= ST_SHIFT;
            settle_q    <= '0;
            shift_cnt_q <= '0;
          end else begin
            settle_q <= settle_q + ST_W'(1);
          end
        end
        ST_SHIFT: begin
          if (hs) begin
            if (last_word) begin
              state_q     <= in_last ? ST_DONE : ST_SE_FALL;
              shift_cnt_q <= '0;
              settle_q    <= '0;
            end else begin
              shift_cnt_q <= shift_cnt_q + SC_W'(1);
            end
          end
        end
        ST_SE_FALL: begin
          if (settle_end) begin
            state_q  <= ST_LAUNCH;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + ST_W'(1);
          end
        end
        ST_LAUNCH: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          state_q   <= ST_SE_RISE;
          settle_q  <= '0;
          pat_cnt_q <= pat_cnt_q + CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  scan_unload_cmp #(.CNT_W(CNT_W)) u_cmp (
    .clk_i           (clock),
    .rst_ni          (reset),
    .clear_i         (session_start),
    .cmp_en_i        (hs),
    .so_i            (test_so_in),
    .exp_i           (in_exp),
    .mask_i          (in_mask),
    .pat_cnt_i       (pat_cnt_q),
    .fail_o          (fail),
    .fail_cnt_o      (fail_cnt),
    .first_fail_pat_o(first_fail_pat)
  );

endmodule

// File: tb/tb_scan_loc_sequencer.sv
// Bench for scan_loc_sequencer: a 16-bit-counter instance driving a modelled two-chain
// core, plus a 4-bit-counter instance used to reach fail_cnt saturation quickly.
module tb_scan_loc_sequencer;

  localparam int CL = 4;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, in_last = 1'b0, sel = 1'b0;
  logic [1:0] in_si = '0, in_exp = '0, in_mask = '0;

  logic        in_ready_m, test_se_m, clk_en_m, busy_m, done_m, fail_m;
  logic [1:0]  si_out_m;
  logic [15:0] fail_cnt_m, pat_cnt_m, ffp_m;
  logic        in_ready_s, test_se_s, clk_en_s, busy_s, done_s, fail_s;
  logic [1:0]  si_out_s;
  logic [3:0]  fail_cnt_s, pat_cnt_s, ffp_s;

  // Scanned core model: two 4-flop chains, capture leaves contents unchanged.
  logic [3:0] c1 = '0, c2 = '0;
  logic [1:0] so_m;
  assign so_m = {c2[3], c1[3]};
  always @(posedge clock) begin
    if (clk_en_m && test_se_m) begin
      c1 <= {c1[2:0], si_out_m[0]};
      c2 <= {c2[2:0], si_out_m[1]};
    end
  end

  scan_loc_sequencer #(.CHAIN_LEN(CL), .SE_SETTLE(SS), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start & ~sel), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_si(in_si), .in_exp(in_exp),
    .in_mask(in_mask), .in_last(in_last), .test_so_in(so_m), .test_si_out(si_out_m),
    .test_se(test_se_m), .dut_clk_en(clk_en_m), .busy(busy_m), .done(done_m),
    .fail(fail_m), .fail_cnt(fail_cnt_m), .pat_cnt(pat_cnt_m), .first_fail_pat(ffp_m)
  );

  scan_loc_sequencer #(.CHAIN_LEN(CL), .SE_SETTLE(SS), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .start(start & sel), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_si(in_si), .in_exp(in_exp),
    .in_mask(in_mask), .in_last(in_last), .test_so_in(2'b00), .test_si_out(si_out_s),
    .test_se(test_se_s), .dut_clk_en(clk_en_s), .busy(busy_s), .done(done_s),
    .fail(fail_s), .fail_cnt(fail_cnt_s), .pat_cnt(pat_cnt_s), .first_fail_pat(ffp_s)
  );

  logic        rdy, obs_done, obs_clk_en, obs_se, obs_busy, obs_fail;
  logic [1:0]  obs_si;
  logic [31:0] obs_fcnt, obs_pat, obs_ffp;
  assign rdy        = sel ? in_ready_s : in_ready_m;
  assign obs_done   = sel ? done_s     : done_m;
  assign obs_clk_en = sel ? clk_en_s   : clk_en_m;
  assign obs_se     = sel ? test_se_s  : test_se_m;
  assign obs_busy   = sel ? busy_s     : busy_m;
  assign obs_fail   = sel ? fail_s     : fail_m;
  assign obs_si     = sel ? si_out_s   : si_out_m;
  assign obs_fcnt   = sel ? 32'(fail_cnt_s) : 32'(fail_cnt_m);
  assign obs_pat    = sel ? 32'(pat_cnt_s)  : 32'(pat_cnt_m);
  assign obs_ffp    = sel ? 32'(ffp_s)      : 32'(ffp_m);

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int pat; int fail; int fcnt; int ffp; int sp; int lp; int sl;
  } res_t;
  logic [1:0] si_q[$];
  res_t       res_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: shift-edge data, launch/capture pulses, scan-enable-low cycles, session results.
  int sp = 0, lp = 0, sl = 0;
  logic done_prev = 1'b0;
  always @(negedge clock) begin
    res_t r;
    if (obs_done && !done_prev) begin
      if (res_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: actual=1 expected=0");
      end else begin
        r = res_q.pop_front();
        check("res_pat_cnt", obs_pat, r.pat);
        check("res_fail", 32'(obs_fail), r.fail);
        check("res_fail_cnt", obs_fcnt, r.fcnt);
        check("res_first_fail_pat", obs_ffp, r.ffp);
        check("res_shift_edges", sp, r.sp);
        check("res_lc_edges", lp, r.lp);
        check("res_se_low_cycles", sl, r.sl);
        check("res_busy", 32'(obs_busy), 0);
      end
    end
    done_prev = obs_done;
    if (start) begin sp = 0; lp = 0; sl = 0; end
    if (obs_clk_en && obs_se) begin
      sp++;
      if (si_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_shift_edge: actual=%0h expected=none", obs_si);
      end else begin
        check("test_si_out", 32'(obs_si), 32'(si_q.pop_front()));
      end
    end
    if (obs_clk_en && !obs_se) lp++;
    if (obs_busy && !obs_se) sl++;
  end

  task automatic send(input logic [1:0] si, input logic [1:0] e, input logic [1:0] m,
                      input logic last);
    int n = 0;
    in_valid = 1'b1; in_si = si; in_exp = e; in_mask = m; in_last = last;
    while (!rdy && n < 50) begin @(posedge clock); #1; n++; end
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=0 required=1");
    end else begin
      si_q.push_back(si);
      @(posedge clock); #1;
    end
  endtask

  task automatic pass(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] e1,
                      input logic [3:0] e2, input logic [1:0] m, input logic last,
                      input int stall_at, input int flip_at);
    for (int j = 0; j < CL; j++) begin
      logic [1:0] e;
      if (j == stall_at) begin
        in_valid = 1'b0;
        repeat (3) begin
          @(negedge clock);
          check("stall_clk_en", 32'(clk_en_m), 0);
          check("stall_shift_cnt", 32'(dut.shift_cnt_q), j);
          @(posedge clock); #1;
        end
      end
      e = {e2[3-j], e1[3-j]};
      if (j == flip_at) e[0] = ~e[0];
      send({s2[3-j], s1[3-j]}, e, m, last && (j == CL - 1));
    end
  endtask

  task automatic begin_session(input logic s);
    sel = s;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!obs_done && n < 100) begin @(posedge clock); #1; n++; end
    if (!obs_done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done=0 required=1");
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
  endtask

  function automatic res_t mk(int pat, int f, int fc, int ffp, int spv, int lpv, int slv);
    res_t r;
    r.pat = pat; r.fail = f; r.fcnt = fc; r.ffp = ffp; r.sp = spv; r.lp = lpv; r.sl = slv;
    return r;
  endfunction

  localparam logic [3:0] A1 = 4'b1010, A2 = 4'b0110;
  localparam logic [3:0] B1 = 4'b0011, B2 = 4'b1100;

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready_m), 0);
    check("rst_test_se", 32'(test_se_m), 0);
    check("rst_clk_en", 32'(clk_en_m), 0);
    check("rst_si_out", 32'(si_out_m), 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("rst_busy", 32'(busy_m), 0);
    check("rst_done", 32'(done_m), 0);
    check("rst_fail", 32'(fail_m), 0);
    check("rst_fail_cnt", 32'(fail_cnt_m), 0);
    check("rst_pat_cnt", 32'(pat_cnt_m), 0);
    check("rst_ffp", 32'(ffp_m), 0);

    // Two patterns plus final unload, everything masked.
    res_q.push_back(mk(2, 0, 0, 0, 12, 4, 8));
    begin_session(1'b0);
    pass(4'b1100, 4'b1001, 4'b1111, 4'b1111, 2'b00, 1'b0, -1, -1);
    pass(4'b0101, 4'b0011, 4'b0000, 4'b1111, 2'b00, 1'b0, -1, -1);
    pass(4'b0000, 4'b0000, 4'b1010, 4'b0101, 2'b00, 1'b1, -1, -1);
    wait_done();

    // Abort during SE_FALL of the second pattern.
    begin_session(1'b0);
    pass(A1, A2, 4'b0000, 4'b0000, 2'b00, 1'b0, -1, -1);
    pass(B1, B2, 4'b0000, 4'b0000, 2'b00, 1'b0, -1, -1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_busy", 32'(busy_m), 0);
    check("abort_test_se", 32'(test_se_m), 0);
    check("abort_clk_en", 32'(clk_en_m), 0);
    check("abort_done", 32'(done_m), 0);
    check("abort_pat_cnt", 32'(pat_cnt_m), 1);
    repeat (6) begin @(posedge clock); #1; end
    check("abort_lc_edges", lp, 2);
    check("abort_shift_edges", sp, 8);
    in_valid = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    check("start_abort_busy", 32'(busy_m), 0);
    check("start_abort_pat_cnt", 32'(pat_cnt_m), 1);
    @(posedge clock); #1;

    // One flipped expectation bit during the second pattern's unload.
    res_q.push_back(mk(2, 1, 1, 1, 12, 4, 8));
    begin_session(1'b0);
    pass(A1, A2, 4'b0000, 4'b0000, 2'b00, 1'b0, -1, -1);
    pass(B1, B2, A1, A2, 2'b11, 1'b0, -1, 1);
    pass(4'b0000, 4'b0000, B1, B2, 2'b11, 1'b1, -1, -1);
    wait_done();

    // Exact expectations with a 3-cycle stall mid-shift.
    res_q.push_back(mk(2, 0, 0, 0, 12, 4, 8));
    begin_session(1'b0);
    pass(A1, A2, 4'b0000, 4'b0000, 2'b00, 1'b0, -1, -1);
    pass(B1, B2, A1, A2, 2'b11, 1'b0, 2, -1);
    pass(4'b0000, 4'b0000, B1, B2, 2'b11, 1'b1, -1, -1);
    wait_done();

    // Reset asserted during CAPTURE; chains hold zeros so all 8 masked bits miscompare.
    begin_session(1'b0);
    pass(A1, A2, 4'b1111, 4'b1111, 2'b11, 1'b0, -1, -1);
    repeat (3) begin @(posedge clock); #1; end
    check("capture_clk_en", 32'(clk_en_m), 1);
    check("capture_test_se", 32'(test_se_m), 0);
    check("capture_fail_cnt", 32'(fail_cnt_m), 8);
    check("capture_fail", 32'(fail_m), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_clk_en", 32'(clk_en_m), 0);
    check("arst_test_se", 32'(test_se_m), 0);
    check("arst_busy", 32'(busy_m), 0);
    check("arst_fail_cnt", 32'(fail_cnt_m), 0);
    in_valid = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("post_rst_busy", 32'(busy_m), 0);
    check("post_rst_in_ready", 32'(in_ready_m), 0);
    check("post_rst_pat_cnt", 32'(pat_cnt_m), 0);
    check("post_rst_fail", 32'(fail_m), 0);
    check("post_rst_ffp", 32'(ffp_m), 0);

    // Both chains miscompare every word on the 4-bit-counter instance: 24 misses, saturates at F.
    res_q.push_back(mk(2, 1, 15, 0, 12, 4, 8));
    begin_session(1'b1);
    pass(4'b1001, 4'b0110, 4'b1111, 4'b1111, 2'b11, 1'b0, -1, -1);
    pass(4'b0101, 4'b1010, 4'b1111, 4'b1111, 2'b11, 1'b0, -1, -1);
    pass(4'b0000, 4'b0000, 4'b1111, 4'b1111, 2'b11, 1'b1, -1, -1);
    wait_done();

    check("si_queue_drained", si_q.size(), 0);
    check("res_queue_drained", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
